twiddle_fetch_ctrl: RTL

Read-side controller for the 4-bank, dual-column twiddle store used by the recover-2N-point FFT stage. On a start pulse it issues `len` paired reads, column 1 ascending and column 2 mirrored descending. It captures the banked read data after the fixed store latency. It delivers each 4×2 twiddle bundle to the butterfly datapath over a valid/ready stream, and never drops a read under backpressure.

---
 rtl/twiddle_fetch_ctrl_if.sv | 37 +++
 rtl/twiddle_fetch_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/twiddle_fetch_ctrl_if.sv
// Twiddle-store read port plus the twiddle bundle stream toward the butterfly.
// Pure wiring, no latency of its own.
// Backpressure travels on tw_ready; the store side has no flow control.
interface twiddle_fetch_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64,
  parameter int NBANK  = 4
);
  logic              rom_valid;
  logic [ADDR_W-1:0] rom_addr_col1;
  logic [ADDR_W-1:0] rom_addr_col2;
  logic [DATA_W-1:0] rom_data_col1 [NBANK-1:0];
  logic [DATA_W-1:0] rom_data_col2 [NBANK-1:0];

  logic              tw_valid;
  logic              tw_ready;
  logic [DATA_W-1:0] tw_col1 [NBANK-1:0];
  logic [DATA_W-1:0] tw_col2 [NBANK-1:0];
  logic [ADDR_W-1:0] tw_index;
  logic              tw_last;

  // Controller side: issues reads, presents bundles.
  modport master (
    output rom_valid, rom_addr_col1, rom_addr_col2,
    input  rom_data_col1, rom_data_col2,
    output tw_valid, tw_col1, tw_col2, tw_index, tw_last,
    input  tw_ready
  );

  // Store + butterfly side.
  modport slave (
    input  rom_valid, rom_addr_col1, rom_addr_col2,
    output rom_data_col1, rom_data_col2,
    input  tw_valid, tw_col1, tw_col2, tw_index, tw_last,
    output tw_ready
  );
endinterface

// File: rtl/twiddle_fetch_ctrl.sv
// Twiddle read controller: len paired reads (col1 ascending, col2 mirrored) into a bundle stream.
// Latency: start in cycle 0, first read cycle 1, first tw_valid cycle 2+ROM_LAT.
// Backpressure: reads throttle so FIFO + in-flight never exceed ROM_LAT+1; nothing is dropped.
module twiddle_fetch_ctrl #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 64,
  parameter int NBANK   = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W:0]      len,
  output logic                 busy,
  output logic                 done,
  twiddle_fetch_ctrl_if.master bus
);
  localparam int DEPTH = ROM_LAT + 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(2 * DEPTH + 1);
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     k_issue;
  logic [ADDR_W-1:0]   addr1_q, addr2_q;

  logic                tag_vld  [ROM_LAT];
  logic [ADDR_W-1:0]   tag_k    [ROM_LAT];
  logic                tag_last [ROM_LAT];

  logic [DATA_W-1:0]   fifo_col1 [DEPTH][NBANK];
  logic [DATA_W-1:0]   fifo_col2 [DEPTH][NBANK];
  logic [ADDR_W-1:0]   fifo_k    [DEPTH];
  logic                fifo_last [DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       fifo_count, inflight;

  logic                issue, issue_last, push, pop;
  logic [ADDR_W-1:0]   col1_addr, col2_addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Count reads still travelling through the store pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) inflight = inflight + CW'(tag_vld[i]);
  end

  assign pop        = bus.tw_valid & bus.tw_ready;
  assign push       = tag_vld[ROM_LAT-1];
  assign col1_addr  = k_issue[ADDR_W-1:0];
  // Modular arithmetic on ADDR_W bits gives the truncated mirror, incl. len = 2^ADDR_W.
  assign col2_addr  = len_q[ADDR_W-1:0] - ADDR_ONE - k_issue[ADDR_W-1:0];
  assign issue_last = (k_issue == len_q - LEN_ONE);
  // A pop this cycle frees a slot, so issue can continue without a bubble.
  assign issue      = (state == ISSUE) &&
                      ((fifo_count + inflight - CW'(pop)) < CW'(DEPTH));

  assign busy              = (state != IDLE);
  assign bus.rom_valid     = issue;
  assign bus.rom_addr_col1 = issue ? col1_addr : addr1_q;
  assign bus.rom_addr_col2 = issue ? col2_addr : addr2_q;
  assign bus.tw_valid      = (fifo_count != '0);
  assign bus.tw_index      = fifo_k[rd_ptr];
  assign bus.tw_last       = fifo_last[rd_ptr];

  // Present the FIFO head bundle.
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      bus.tw_col1[b] = fifo_col1[rd_ptr][b];
      bus.tw_col2[b] = fifo_col2[rd_ptr][b];
    end
  end

  // Job FSM: latch length, walk k, finish on pop of the last bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      len_q   <= '0;
      k_issue <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state   <= ISSUE;
              len_q   <= len;
              k_issue <= '0;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            k_issue <= k_issue + LEN_ONE;
            if (issue_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && bus.tw_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address hold, in-flight tag pipeline and output FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr1_q    <= '0;
      addr2_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_vld[i]  <= 1'b0;
        tag_k[i]    <= '0;
        tag_last[i] <= 1'b0;
      end
      for (int d = 0; d < DEPTH; d++) begin
        fifo_k[d]    <= '0;
        fifo_last[d] <= 1'b0;
        for (int b = 0; b < NBANK; b++) begin
          fifo_col1[d][b] <= '0;
          fifo_col2[d][b] <= '0;
        end
      end
    end else begin
      if (issue) begin
        addr1_q <= col1_addr;
        addr2_q <= col2_addr;
      end
      tag_vld[0]  <= issue;
      tag_k[0]    <= col1_addr;
      tag_last[0] <= issue_last;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_k[i]    <= tag_k[i-1];
        tag_last[i] <= tag_last[i-1];
      end
      if (push) begin
        for (int b = 0; b < NBANK; b++) begin
          fifo_col1[wr_ptr][b] <= bus.rom_data_col1[b];
          fifo_col2[wr_ptr][b] <= bus.rom_data_col2[b];
        end
        fifo_k[wr_ptr]    <= tag_k[ROM_LAT-1];
        fifo_last[wr_ptr] <= tag_last[ROM_LAT-1];
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end
endmodule
